// File: rtl/pulse_scheduler.sv
// Shared pulse-train generator: a round-robin arbiter picks one requester and an FSM
// drives n_pulses periods of high_len cycles high / low_len cycles low on 'signal'.
module pulse_scheduler #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [CNT_W-1:0] n_pulses,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             signal,
  output logic             done
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [N_REQ-1:0] GNT_ZERO = {N_REQ{1'b0}};
  localparam logic [N_REQ-1:0] GNT_ONE  = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             signal_q, signal_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] high_m1_q, high_m1_d;
  logic [CNT_W-1:0] low_m1_q, low_m1_d;
  logic [CNT_W-1:0] pulses_q, pulses_d;
  logic [CNT_W-1:0] phase_q, phase_d;

  logic             found_s;
  logic [IDX_W-1:0] pick_s;
  logic [IDX_W-1:0] cand_s;

  // Phase counters hold (effective length - 1); a zero length behaves as one cycle.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
    return (len == CNT_ZERO) ? CNT_ZERO : (len - CNT_ONE);
  endfunction

  // Round-robin search: first set request at or above ptr, wrapping around.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {IDX_W{1'b0}};
    cand_s  = {IDX_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      cand_s = IDX_W'((int'(ptr_q) + i) % N_REQ);
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    signal_d  = 1'b0;
    done_d    = 1'b0;
    high_m1_d = high_m1_q;
    low_m1_d  = low_m1_q;
    pulses_d  = pulses_q;
    phase_d   = phase_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          grant_d   = GNT_ONE << pick_s;
          idx_d     = pick_s;
          busy_d    = 1'b1;
          high_m1_d = len_m1(high_len);
          low_m1_d  = len_m1(low_len);
          pulses_d  = n_pulses;
          if (n_pulses == CNT_ZERO) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = S_HIGH;
            signal_d = 1'b1;
            phase_d  = len_m1(high_len);
          end
        end else begin
          grant_d = GNT_ZERO;
          busy_d  = 1'b0;
        end
      end
      S_HIGH: begin
        if (phase_q == CNT_ZERO) begin
          state_d = S_LOW;
          phase_d = low_m1_q;
        end else begin
          signal_d = 1'b1;
          phase_d  = phase_q - CNT_ONE;
        end
      end
      S_LOW: begin
        if (phase_q == CNT_ZERO) begin
          pulses_d = pulses_q - CNT_ONE;
          if (pulses_q > CNT_ONE) begin
            state_d  = S_HIGH;
            signal_d = 1'b1;
            phase_d  = high_m1_q;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          phase_d = phase_q - CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = GNT_ZERO;
        busy_d  = 1'b0;
        ptr_d   = IDX_W'((int'(idx_q) + 1) % N_REQ);
      end
      default: begin
        state_d = S_IDLE;
        grant_d = GNT_ZERO;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= {IDX_W{1'b0}};
      idx_q     <= {IDX_W{1'b0}};
      grant_q   <= GNT_ZERO;
      busy_q    <= 1'b0;
      signal_q  <= 1'b0;
      done_q    <= 1'b0;
      high_m1_q <= CNT_ZERO;
      low_m1_q  <= CNT_ZERO;
      pulses_q  <= CNT_ZERO;
      phase_q   <= CNT_ZERO;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      signal_q  <= signal_d;
      done_q    <= done_d;
      high_m1_q <= high_m1_d;
      low_m1_q  <= low_m1_d;
      pulses_q  <= pulses_d;
      phase_q   <= phase_d;
    end
  end

  assign grant  = grant_q;
  assign busy   = busy_q;
  assign signal = signal_q;
  assign done   = done_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Scoreboard bench for pulse_scheduler: expected per-cycle {grant,signal,done} tuples are
// queued at stimulus time and popped by a negedge monitor on every busy cycle.
module tb_pulse_scheduler;

  logic       clock;
  logic       reset_n;
  logic [3:0] req;
  logic [7:0] high_len;
  logic [7:0] low_len;
  logic [7:0] n_pulses;
  logic [3:0] grant;
  logic       busy;
  logic       signal;
  logic       done;

  typedef struct packed {
    logic [3:0] g;
    logic       s;
    logic       d;
  } exp_t;

  exp_t sb[$];
  int   rise_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;

  pulse_scheduler #(.N_REQ(4), .CNT_W(8)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .high_len (high_len),
    .low_len  (low_len),
    .n_pulses (n_pulses),
    .grant    (grant),
    .busy     (busy),
    .signal   (signal),
    .done     (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Expected tuples for one burst: effective lengths are max(x,1).
  task automatic push_burst(input logic [3:0] g, input int h, input int l, input int n);
    int eh;
    int el;
    eh = (h == 0) ? 1 : h;
    el = (l == 0) ? 1 : l;
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < eh; i++) sb.push_back('{g: g, s: 1'b1, d: 1'b0});
      for (int i = 0; i < el; i++) sb.push_back('{g: g, s: 1'b0, d: 1'b0});
    end
    sb.push_back('{g: g, s: 1'b0, d: 1'b1});
  endtask

  // Monitor: pops one expected tuple per busy cycle, checks idle cycles are quiet.
  initial begin
    exp_t e;
    logic prev_busy;
    logic prev_done;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        cyc++;
        if (prev_done) begin
          checks++;
          if (busy !== 1'b0 || grant !== 4'b0000) begin
            errors++;
            $display("FAIL gap_after_done: act busy=%b grant=%b exp busy=0 grant=0000", busy, grant);
          end
        end
        if (busy === 1'b1) begin
          if (!prev_busy) rise_q.push_back(cyc);
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_busy: act grant=%b signal=%b done=%b exp idle", grant, signal, done);
          end else begin
            e = sb.pop_front();
            if ({grant, signal, done} !== {e.g, e.s, e.d}) begin
              errors++;
              $display("FAIL burst_cycle: act g=%b s=%b d=%b exp g=%b s=%b d=%b",
                       grant, signal, done, e.g, e.s, e.d);
            end
          end
        end else begin
          checks++;
          if (grant !== 4'b0000 || signal !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: act g=%b s=%b d=%b exp 0000/0/0", grant, signal, done);
          end
        end
        prev_busy = (busy === 1'b1);
        prev_done = (done === 1'b1);
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 4'b0000;
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("reset_grant", {28'd0, grant}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_signal", {31'd0, signal}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    rise_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic wait_rises(input int n, input int budget);
    int b;
    b = budget;
    while (rise_q.size() < n && b > 0) begin
      @(negedge clock);
      #1;
      b--;
    end
    if (rise_q.size() < n) begin
      errors++;
      $display("FAIL wait_grant: act rises=%0d exp rises=%0d", rise_q.size(), n);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int b;
    b = budget;
    while ((busy !== 1'b0 || sb.size() != 0) && b > 0) begin
      @(negedge clock);
      #1;
      b--;
    end
    chk({name, "_sb_empty"}, sb.size(), 32'd0);
    chk({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_single(input string name, input logic [3:0] r, input logic [3:0] g,
                            input int h, input int l, input int n);
    high_len = 8'(h);
    low_len  = 8'(l);
    n_pulses = 8'(n);
    push_burst(g, h, l, n);
    req = r;
    wait_rises(1, 20);
    req = 4'b0000;
    wait_idle(name, 1200);
  endtask

  initial begin
    reset_n  = 1'b0;
    req      = 4'b0000;
    high_len = 8'd0;
    low_len  = 8'd0;
    n_pulses = 8'd0;

    // 1. single burst 110011001100 + done, 13 grant cycles
    do_reset();
    run_single("single", 4'b0001, 4'b0001, 2, 2, 3);

    // 2. round robin with all requests held
    do_reset();
    high_len = 8'd1;
    low_len  = 8'd1;
    n_pulses = 8'd1;
    push_burst(4'b0001, 1, 1, 1);
    push_burst(4'b0010, 1, 1, 1);
    push_burst(4'b0100, 1, 1, 1);
    push_burst(4'b1000, 1, 1, 1);
    push_burst(4'b0001, 1, 1, 1);
    req = 4'b1111;
    wait_rises(5, 100);
    req = 4'b0000;
    wait_idle("rr", 50);
    for (int i = 0; i + 1 < rise_q.size(); i++)
      chk("rr_spacing", 32'(rise_q[i+1] - rise_q[i]), 32'd4);

    // 3. zero fields
    do_reset();
    run_single("zero_len", 4'b0001, 4'b0001, 0, 0, 2);
    do_reset();
    run_single("zero_n", 4'b0001, 4'b0001, 3, 3, 0);

    // 4. non-preemption: inputs change mid-burst, req2 waits for DONE+IDLE
    do_reset();
    high_len = 8'd3;
    low_len  = 8'd2;
    n_pulses = 8'd2;
    push_burst(4'b0001, 3, 2, 2);
    push_burst(4'b0100, 7, 2, 2);
    req = 4'b0001;
    wait_rises(1, 20);
    req      = 4'b0100;
    high_len = 8'd7;
    wait_rises(2, 60);
    req = 4'b0000;
    wait_idle("nonpreempt", 100);
    if (rise_q.size() == 2) chk("nonpreempt_spacing", 32'(rise_q[1] - rise_q[0]), 32'd12);
    else chk("nonpreempt_rises", rise_q.size(), 32'd2);

    // 5. reset during HIGH, then pointer restarts from 0
    do_reset();
    high_len = 8'd5;
    low_len  = 8'd1;
    n_pulses = 8'd1;
    sb.push_back('{g: 4'b0001, s: 1'b1, d: 1'b0});
    sb.push_back('{g: 4'b0001, s: 1'b1, d: 1'b0});
    req = 4'b0001;
    wait_rises(1, 20);
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    req     = 4'b0110;
    @(negedge clock);
    #1;
    chk("midreset_signal", {31'd0, signal}, 32'd0);
    chk("midreset_grant", {28'd0, grant}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_sb", sb.size(), 32'd0);
    push_burst(4'b0010, 5, 1, 1);
    rise_q.delete();
    reset_n = 1'b1;
    wait_rises(1, 20);
    req = 4'b0000;
    wait_idle("after_reset", 50);

    // 6. maximum lengths: 255 high, 255 low, done in cycle 511
    do_reset();
    run_single("max", 4'b1000, 4'b1000, 255, 255, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
